// File: rtl/mont_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mont_arbiter_pkg
// Shared definitions for the two-requester Montgomery-core arbiter:
//   - FSM state encoding (IDLE, START, BUSY, RESP)
//   - default operand width and default timeout budget
//   - helper that sizes the timeout counter from the timeout budget
// -----------------------------------------------------------------------------
package mont_arbiter_pkg;

    localparam int WIDTH_DEF       = 1024;
    localparam int TIMEOUT_CYC_DEF = 8192;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Counter width is clog2 of the budget; a budget of 1 would give zero bits,
    // so keep at least one bit to stay legal.
    function automatic int cnt_width(input int cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/mont_arbiter_if.sv
// -----------------------------------------------------------------------------
// mont_arbiter_if
// Request/response bus between two requesters and the arbiter.
//   req_valid[1:0]   requester -> arbiter  per-requester request, operands stable while high
//   req_ready[1:0]   arbiter -> requester  one-cycle accept pulse
//   req0_a/b/m       requester 0 operands (a, b, modulus)
//   req1_a/b/m       requester 1 operands
//   rsp_valid[1:0]   arbiter -> requester  response valid, held until accepted
//   rsp_ready[1:0]   requester -> arbiter  response accept
//   rsp_result       result for the requester whose rsp_valid is high
//   rsp_error        timeout flag qualifying rsp_result
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface mont_arbiter_if
    import mont_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req0_m;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [WIDTH-1:0] req1_m;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_error;

    modport master (
        output req_valid, req0_a, req0_b, req0_m, req1_a, req1_b, req1_m, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_error
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req0_m, req1_a, req1_b, req1_m, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_error
    );

endinterface

// File: rtl/mont_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin selector. The requester named by ptr wins if it is
// requesting; otherwise the other requester wins if it is requesting.
//   valid[1:0]  in   request vector
//   ptr         in   favoured requester index
//   grant[1:0]  out  one-hot grant (all zero when nobody requests)
//   any         out  at least one request present
// -----------------------------------------------------------------------------
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       any
);

    // NOTE: grant is given a default before the if-chain so no latch is inferred.
    always_comb begin
        grant = 2'b00;
        if (valid[ptr]) begin
            grant[ptr] = 1'b1;
        end else if (valid[~ptr]) begin
            grant[~ptr] = 1'b1;
        end
    end

    assign any = |valid;

endmodule

// File: rtl/mont_arbiter.sv
// -----------------------------------------------------------------------------
// mont_arbiter
// Shares one Montgomery multiplier core between two requesters. One operation
// is in flight at a time: IDLE grants a requester round-robin and latches its
// operands, START pulses core_start, BUSY waits for core_done (with a timeout
// that resets the core), RESP holds the response until the owner accepts it.
//   clk           in   single clock, rising edge
//   reset         in   synchronous active-high reset
//   bus           slave modport of mont_arbiter_if (request/response side)
//   core_resetn   out  active-low core reset (reset, or one cycle on timeout)
//   core_start    out  one-cycle start pulse
//   core_in_a/b/m out  operands held from grant to the next grant
//   core_result   in   core result
//   core_done     in   completion flag, sticky until the next core_start
// -----------------------------------------------------------------------------
module mont_arbiter
    import mont_arbiter_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    mont_arbiter_if.slave    bus,
    output logic             core_resetn,
    output logic             core_start,
    output logic [WIDTH-1:0] core_in_a,
    output logic [WIDTH-1:0] core_in_b,
    output logic [WIDTH-1:0] core_in_m,
    input  logic [WIDTH-1:0] core_result,
    input  logic             core_done
);

    localparam int              CNT_W    = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic             ptr;
    logic             owner;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] result_q;
    logic             error_q;

    logic [1:0]       grant;
    logic             grant_any;
    logic             grant_idx;
    logic             done_hit;
    logic             timeout_hit;
    logic             rsp_accept;

    rr_pick2 u_pick (
        .valid (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .any   (grant_any)
    );

    // grant is one-hot, so bit 1 is the winning index.
    assign grant_idx = grant[1];

    // Next state and all FSM-driven outputs.
    always_comb begin
        state_nxt     = state;
        done_hit      = 1'b0;
        timeout_hit   = 1'b0;
        rsp_accept    = 1'b0;
        bus.req_ready = 2'b00;
        bus.rsp_valid = 2'b00;
        core_start    = 1'b0;
        core_resetn   = 1'b1;

        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = START;
                end
                bus.req_ready = grant;
            end
            START: begin
                // core_done is deliberately not looked at here: it may still be
                // high from the previous operation until this start is seen.
                core_start = 1'b1;
                state_nxt  = BUSY;
            end
            BUSY: begin
                // done is tested first so it wins over a same-cycle timeout.
                if (core_done) begin
                    done_hit  = 1'b1;
                    state_nxt = RESP;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    core_resetn = 1'b0;
                    state_nxt   = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid[owner] = 1'b1;
                if (bus.rsp_ready[owner]) begin
                    rsp_accept = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Reset overrides everything the FSM would drive this cycle.
        if (reset) begin
            bus.req_ready = 2'b00;
            bus.rsp_valid = 2'b00;
            core_start    = 1'b0;
            core_resetn   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and they all update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= 1'b0;
            owner     <= 1'b0;
            cnt       <= '0;
            result_q  <= '0;
            error_q   <= 1'b0;
            core_in_a <= '0;
            core_in_b <= '0;
            core_in_m <= '0;
        end else begin
            // Operands are captured only on a grant, so they stay put for the
            // whole operation and until the next grant.
            if (state == IDLE && grant_any) begin
                owner     <= grant_idx;
                core_in_a <= grant_idx ? bus.req1_a : bus.req0_a;
                core_in_b <= grant_idx ? bus.req1_b : bus.req0_b;
                core_in_m <= grant_idx ? bus.req1_m : bus.req0_m;
            end

            if (state == START) begin
                cnt <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (done_hit) begin
                result_q <= core_result;
                error_q  <= 1'b0;
            end else if (timeout_hit) begin
                result_q <= '0;
                error_q  <= 1'b1;
            end

            // After a response is taken the other requester is favoured.
            if (rsp_accept) begin
                ptr <= ~owner;
            end
        end
    end

    assign bus.rsp_result = result_q;
    assign bus.rsp_error  = error_q;

endmodule

// File: tb/tb_mont_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mont_arbiter
// Directed bench for mont_arbiter with a core stub (result = a ^ b after a
// programmable latency, or never). A transaction-level model predicts every
// output each cycle; directed sections add literal expectations.
// -----------------------------------------------------------------------------
module tb_mont_arbiter;
    import mont_arbiter_pkg::*;

    localparam int W  = 128;
    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         core_resetn;
    logic         core_start;
    logic [W-1:0] core_in_a;
    logic [W-1:0] core_in_b;
    logic [W-1:0] core_in_m;
    logic [W-1:0] core_result = '0;
    logic         core_done   = 1'b0;

    always #5 clk = ~clk;

    mont_arbiter_if #(.WIDTH(W)) bus ();

    mont_arbiter #(.WIDTH(W), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .core_resetn (core_resetn),
        .core_start  (core_start),
        .core_in_a   (core_in_a),
        .core_in_b   (core_in_b),
        .core_in_m   (core_in_m),
        .core_result (core_result),
        .core_done   (core_done)
    );

    // ---------------- core stub ----------------
    int stub_lat   = 10;
    bit stub_never = 1'b0;
    int stub_cnt   = 0;

    // done rises stub_lat cycles after the core_start cycle and stays high
    // until the next start or core reset (stub_lat must be >= 2).
    always @(posedge clk) begin
        if (!core_resetn) begin
            core_done <= 1'b0;
            stub_cnt  <= 0;
        end else if (core_start) begin
            core_done <= 1'b0;
            stub_cnt  <= stub_never ? 0 : stub_lat - 1;
        end else if (stub_cnt == 1) begin
            core_done   <= 1'b1;
            core_result <= core_in_a ^ core_in_b;
            stub_cnt    <= 0;
        end else if (stub_cnt > 1) begin
            stub_cnt <= stub_cnt - 1;
        end
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int grant_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    bit           m_busy  = 1'b0;
    int           m_owner = 0;
    int           m_ptr   = 0;
    int           m_acc   = 0;
    int           m_resp  = 0;
    bit           m_err   = 1'b0;
    logic [W-1:0] m_a = '0, m_b = '0, m_m = '0, m_res = '0;

    initial begin : compare
        logic [1:0] exp_rdy, exp_vld;
        logic       exp_start, exp_rstn;
        int         g, eff;
        forever begin
            @(negedge clk);
            exp_rdy   = 2'b00;
            exp_vld   = 2'b00;
            exp_start = 1'b0;
            exp_rstn  = 1'b1;
            g         = -1;
            if (reset) begin
                exp_rstn = 1'b0;
            end else if (!m_busy) begin
                if (bus.req_valid[m_ptr])          g = m_ptr;
                else if (bus.req_valid[1 - m_ptr]) g = 1 - m_ptr;
                if (g >= 0) exp_rdy[g] = 1'b1;
            end else begin
                if (cyc == m_acc + 1)           exp_start = 1'b1;
                if (m_err && cyc == m_resp - 1) exp_rstn  = 1'b0;
                if (cyc >= m_resp)              exp_vld[m_owner] = 1'b1;
            end

            check("req_ready", bus.req_ready, exp_rdy);
            check("rsp_valid", bus.rsp_valid, exp_vld);
            check("core_start", core_start, exp_start);
            check("core_resetn", core_resetn, exp_rstn);
            check("core_in_a", core_in_a, m_a);
            check("core_in_b", core_in_b, m_b);
            check("core_in_m", core_in_m, m_m);
            if (exp_vld != 2'b00) begin
                check("rsp_result", bus.rsp_result, m_res);
                check("rsp_error", bus.rsp_error, m_err);
            end

            // Advance the model by what the coming edge does.
            if (reset) begin
                m_busy = 1'b0;
                m_ptr  = 0;
                m_a    = '0;
                m_b    = '0;
                m_m    = '0;
            end else if (!m_busy && g >= 0) begin
                grant_log.push_back(g);
                m_busy  = 1'b1;
                m_owner = g;
                m_acc   = cyc;
                m_a     = g ? bus.req1_a : bus.req0_a;
                m_b     = g ? bus.req1_b : bus.req0_b;
                m_m     = g ? bus.req1_m : bus.req0_m;
                m_err   = stub_never || stub_lat > TO;
                eff     = m_err ? TO : stub_lat;
                m_resp  = cyc + 2 + eff;
                m_res   = m_err ? '0 : (m_a ^ m_b);
            end else if (m_busy && cyc >= m_resp && bus.rsp_ready[m_owner]) begin
                m_busy = 1'b0;
                m_ptr  = 1 - m_owner;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] m);
        if (r == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_m = m;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_m = m;
        end
        bus.req_valid[r] = 1'b1;
    endtask

    task automatic wait_ready(input int r, output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req_ready[r]) begin
                at = cyc;
                break;
            end
        end
        check("req_ready seen", at >= 0, 1'b1);
    endtask

    task automatic wait_rsp(input int r, output int at);
        at = -1;
        for (int i = 0; i < TO + 40; i++) begin
            @(negedge clk);
            if (bus.rsp_valid[r]) begin
                at = cyc;
                break;
            end
        end
        check("rsp_valid seen", at >= 0, 1'b1);
    endtask

    task automatic accept(input int r);
        tick();
        bus.rsp_ready[r] = 1'b1;
        tick();
        bus.rsp_ready[r] = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stim
        int acc, at, pulses, lows, silent;
        reset         = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        set_req(0, '0, '0, '0);
        set_req(1, '0, '0, '0);
        bus.req_valid = 2'b00;

        repeat (2) tick();
        @(negedge clk);
        check("reset req_ready", bus.req_ready, 2'b00);
        check("reset rsp_valid", bus.rsp_valid, 2'b00);
        check("reset core_start", core_start, 1'b0);
        check("reset core_resetn", core_resetn, 1'b0);
        tick();
        reset = 1'b0;

        // Single request, latency 10.
        stub_lat = 10;
        set_req(0, 'h3, 'h5, 'h7);
        wait_ready(0, acc);
        tick();
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("t1 core_start", core_start, 1'b1);
        check("t1 core_in_m", core_in_m, 'h7);
        repeat (10) @(negedge clk);
        check("t1 no early rsp", bus.rsp_valid, 2'b00);
        @(negedge clk);
        check("t1 rsp_valid", bus.rsp_valid, 2'b01);
        check("t1 result", bus.rsp_result, 'h6);
        check("t1 error", bus.rsp_error, 1'b0);
        accept(0);

        // Stale done from the previous operation is still high through START.
        stub_lat = 6;
        tick();
        set_req(0, 'hF0, 'h0F, 'h11);
        wait_ready(0, acc);
        tick();
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("stale done present", core_done, 1'b1);
        @(negedge clk);
        check("stale ignored", bus.rsp_valid, 2'b00);
        wait_rsp(0, at);
        check("stale latency", at - acc, 8);
        check("stale result", bus.rsp_result, 'hFF);
        accept(0);

        // Both requesters after reset: grants alternate 0,1,0,1.
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        grant_log.delete();
        stub_lat      = 4;
        bus.rsp_ready = 2'b11;
        fork
            begin : thr0
                int t;
                for (int k = 0; k < 2; k++) begin
                    tick();
                    set_req(0, W'(16 + k), W'(3), W'(101));
                    wait_ready(0, t);
                    tick();
                    bus.req_valid[0] = 1'b0;
                    wait_rsp(0, t);
                end
            end
            begin : thr1
                int t;
                for (int k = 0; k < 2; k++) begin
                    tick();
                    set_req(1, W'(32 + k), W'(5), W'(103));
                    wait_ready(1, t);
                    tick();
                    bus.req_valid[1] = 1'b0;
                    wait_rsp(1, t);
                end
            end
        join
        tick();
        bus.rsp_ready = 2'b00;
        check("rr grant count", grant_log.size(), 4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++)
            check("rr grant order", grant_log[k], k % 2);

        // Backpressure: owner 0 holds off 20 cycles, non-owner ready ignored.
        stub_lat = 3;
        tick();
        set_req(0, 'hAA, 'h55, 'h101);
        wait_ready(0, acc);
        tick();
        bus.req_valid = 2'b00;
        wait_rsp(0, at);
        tick();
        set_req(1, 'h1234, 'h00FF, 'h2001);
        bus.rsp_ready = 2'b10;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready[1]) pulses++;
            check("bp rsp_valid held", bus.rsp_valid, 2'b01);
            check("bp result held", bus.rsp_result, 'hFF);
        end
        check("bp no grant to 1", pulses, 0);
        tick();
        bus.rsp_ready = 2'b01;
        tick();
        bus.rsp_ready = 2'b00;
        wait_ready(1, acc);
        tick();
        bus.req_valid = 2'b00;
        wait_rsp(1, at);
        check("bp req1 result", bus.rsp_result, 'h12CB);
        accept(1);

        // Timeout: the core never finishes.
        stub_never = 1'b1;
        tick();
        set_req(0, 'h12, 'h34, 'h57);
        wait_ready(0, acc);
        tick();
        bus.req_valid = 2'b00;
        lows = 0;
        at   = -1;
        for (int i = 0; i < TO + 20; i++) begin
            @(negedge clk);
            if (!core_resetn) lows++;
            if (bus.rsp_valid[0]) begin
                at = cyc;
                break;
            end
        end
        check("to latency", at - acc, TO + 2);
        check("to error", bus.rsp_error, 1'b1);
        check("to result", bus.rsp_result, '0);
        check("to core_resetn pulses", lows, 1);
        stub_never = 1'b0;
        accept(0);

        // Next request after the timeout is served normally.
        stub_lat = 5;
        tick();
        set_req(0, 'h9, 'h6, 'hB);
        wait_ready(0, acc);
        tick();
        bus.req_valid = 2'b00;
        wait_rsp(0, at);
        check("post-to latency", at - acc, 7);
        check("post-to result", bus.rsp_result, 'hF);
        check("post-to error", bus.rsp_error, 1'b0);
        accept(0);

        // Reset in BUSY cycle 5 of a requester-1 operation (pointer is 1 here).
        stub_lat = 20;
        tick();
        set_req(1, 'h77, 'h11, 'h99);
        wait_ready(1, acc);
        tick();
        bus.req_valid = 2'b00;
        repeat (6) tick();
        reset = 1'b1;
        @(negedge clk);
        check("mid reset cycle", cyc - acc, 7);
        check("mid reset core_resetn", core_resetn, 1'b0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post reset rsp_valid", bus.rsp_valid, 2'b00);
        silent = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) silent++;
        end
        check("no rsp after reset", silent, 0);
        tick();
        set_req(0, 'h5, 'h3, 'h7);
        set_req(1, 'h8, 'h1, 'h7);
        @(negedge clk);
        check("ptr reset grants 0", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        wait_rsp(0, at);
        check("post reset result", bus.rsp_result, 'h6);
        accept(0);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
